// File: rtl/seg_history_pkg.sv
// Shared types and constants for the seg_history display block:
// blink FSM states, the blank pattern and the active-low segment table.
package seg_history_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } blink_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Packed table, element 0 is the rightmost entry; patterns are {g,f,e,d,c,b,a}, active low.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg_history_if.sv
// Bus between the observed stage and the seg_history display block:
// the watched nibble in, four digit patterns plus status out.
interface seg_history_if;

  logic [3:0] data_in;
  logic [6:0] hex0;
  logic [6:0] hex1;
  logic [6:0] hex2;
  logic [6:0] hex3;
  logic       busy;
  logic [7:0] upd_cnt;

  modport master (
    output data_in,
    input  hex0, hex1, hex2, hex3, busy, upd_cnt
  );

  modport slave (
    input  data_in,
    output hex0, hex1, hex2, hex3, busy, upd_cnt
  );

endinterface

// File: rtl/seg_history_hex_to_seg.sv
// Combinational 4-bit value to 7-segment active-low pattern decoder.
module hex_to_seg
  import seg_history_pkg::*;
(
  input  logic [3:0] val_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[val_i];

endmodule

// File: rtl/seg_history.sv
// Keeps the last four distinct values seen on data_in, shows them on four
// seven-segment digits and blinks the newest digit after every change.
module seg_history
  import seg_history_pkg::*;
#(
  parameter int BLINK_HALF = 25_000_000,
  parameter int BLINKS     = 3
) (
  input  logic          clk,
  input  logic          rst,
  seg_history_if.slave  bus
);

  localparam int              CNT_W     = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_HALF - 1);
  localparam logic [3:0]      LEFT_INIT = 4'(BLINKS);

  logic [3:0][3:0]  hist_q, hist_d;
  logic [3:0]       valid_q, valid_d;
  logic [7:0]       upd_cnt_q, upd_cnt_d;
  blink_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       left_q, left_d;
  logic             update_s;
  logic [3:0][6:0]  seg_s;

  assign update_s = !valid_q[0] || (bus.data_in != hist_q[0]);

  // History shift register and update counter next state.
  always_comb begin
    hist_d    = hist_q;
    valid_d   = valid_q;
    upd_cnt_d = upd_cnt_q;
    if (update_s) begin
      hist_d    = {hist_q[2:0], bus.data_in};
      valid_d   = {valid_q[2:0], 1'b1};
      upd_cnt_d = upd_cnt_q + 8'd1;
    end else begin
      hist_d    = hist_q;
      valid_d   = valid_q;
      upd_cnt_d = upd_cnt_q;
    end
  end

  // Blink FSM next state: any update restarts the full ON/OFF sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    if (update_s) begin
      state_d = ST_ON;
      cnt_d   = '0;
      left_d  = LEFT_INIT;
    end else begin
      case (state_q)
        ST_ON: begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_OFF;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_OFF: begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            left_d  = left_q - 4'd1;
            state_d = (left_q == 4'd1) ? ST_IDLE : ST_ON;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          left_d  = 4'd0;
        end
      endcase
    end
  end

  // State registers with synchronous reset; reset overrides a same-edge capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q    <= '0;
      valid_q   <= 4'd0;
      upd_cnt_q <= 8'd0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      left_q    <= 4'd0;
    end else begin
      hist_q    <= hist_d;
      valid_q   <= valid_d;
      upd_cnt_q <= upd_cnt_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      left_q    <= left_d;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_dec
    hex_to_seg u_dec (
      .val_i (hist_q[i]),
      .seg_o (seg_s[i])
    );
  end

  // Only the newest digit blinks; empty history slots stay blank.
  assign bus.hex0    = (valid_q[0] && (state_q != ST_OFF)) ? seg_s[0] : SEG_BLANK;
  assign bus.hex1    = valid_q[1] ? seg_s[1] : SEG_BLANK;
  assign bus.hex2    = valid_q[2] ? seg_s[2] : SEG_BLANK;
  assign bus.hex3    = valid_q[3] ? seg_s[3] : SEG_BLANK;
  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.upd_cnt = upd_cnt_q;

endmodule

// File: tb/tb_seg_history.sv
// Self-checking bench for seg_history: directed vector table, corner-case
// sequences and random stimulus against a queue-based reference model.
module tb_seg_history;

  localparam int BH = 2;
  localparam int NB = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg_history_if bus ();

  seg_history #(.BLINK_HALF(BH), .BLINKS(NB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [6:0] seg_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: newest value at the front, age of the last update in cycles.
  int m_hist[$];
  int m_upd   = 0;
  int m_since = -1;

  typedef struct {
    logic       r;
    logic [3:0] d;
    logic [6:0] h0, h1, h2, h3;
    logic       b;
    logic [7:0] u;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(logic r, logic [3:0] d, logic [6:0] h0, logic [6:0] h1,
                              logic [6:0] h2, logic [6:0] h3, logic b, logic [7:0] u);
    vec_t v;
    v.r = r; v.d = d; v.h0 = h0; v.h1 = h1; v.h2 = h2; v.h3 = h3; v.b = b; v.u = u;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic m_step(input logic r, input logic [3:0] d);
    if (r) begin
      m_hist.delete();
      m_upd   = 0;
      m_since = -1;
    end else if (m_hist.size() == 0 || int'(d) != m_hist[0]) begin
      m_hist.push_front(int'(d));
      if (m_hist.size() > 4) void'(m_hist.pop_back());
      m_upd   = (m_upd + 1) % 256;
      m_since = 0;
    end else if (m_since >= 0 && m_since < 100000) begin
      m_since++;
    end
  endtask

  function automatic int m_busy();
    return (m_since >= 0 && m_since < 2 * BH * NB) ? 1 : 0;
  endfunction

  function automatic int m_hex(int n);
    if (n >= m_hist.size()) return 'h7F;
    if (n == 0 && m_busy() == 1 && ((m_since / BH) % 2) == 1) return 'h7F;
    return int'(seg_ref[m_hist[n]]);
  endfunction

  task automatic check_model(input string tag);
    chk({tag, ".hex0"}, int'(bus.hex0), m_hex(0));
    chk({tag, ".hex1"}, int'(bus.hex1), m_hex(1));
    chk({tag, ".hex2"}, int'(bus.hex2), m_hex(2));
    chk({tag, ".hex3"}, int'(bus.hex3), m_hex(3));
    chk({tag, ".busy"}, int'(bus.busy), m_busy());
    chk({tag, ".upd"},  int'(bus.upd_cnt), m_upd);
  endtask

  task automatic cyc(input logic r, input logic [3:0] d);
    rst         = r;
    bus.data_in = d;
    @(posedge clk);
    m_step(r, d);
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    bus.data_in = 4'h5;

    // Reset, first capture, blink timing, repeat hold, change-back, reset mid-blink.
    tbl[0]  = mk(1'b1, 4'h5, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 1'b0, 8'd0);
    tbl[1]  = mk(1'b1, 4'h5, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 1'b0, 8'd0);
    tbl[2]  = mk(1'b0, 4'h5, 7'h12, 7'h7F, 7'h7F, 7'h7F, 1'b1, 8'd1);
    tbl[3]  = mk(1'b0, 4'h5, 7'h12, 7'h7F, 7'h7F, 7'h7F, 1'b1, 8'd1);
    tbl[4]  = mk(1'b0, 4'h5, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 1'b1, 8'd1);
    tbl[5]  = mk(1'b0, 4'h5, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 1'b1, 8'd1);
    tbl[6]  = mk(1'b0, 4'h5, 7'h12, 7'h7F, 7'h7F, 7'h7F, 1'b1, 8'd1);
    tbl[7]  = mk(1'b0, 4'h5, 7'h12, 7'h7F, 7'h7F, 7'h7F, 1'b1, 8'd1);
    tbl[8]  = mk(1'b0, 4'h5, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 1'b1, 8'd1);
    tbl[9]  = mk(1'b0, 4'h5, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 1'b1, 8'd1);
    tbl[10] = mk(1'b0, 4'h5, 7'h12, 7'h7F, 7'h7F, 7'h7F, 1'b0, 8'd1);
    tbl[11] = mk(1'b0, 4'h5, 7'h12, 7'h7F, 7'h7F, 7'h7F, 1'b0, 8'd1);
    tbl[12] = mk(1'b0, 4'h3, 7'h30, 7'h12, 7'h7F, 7'h7F, 1'b1, 8'd2);
    tbl[13] = mk(1'b0, 4'h3, 7'h30, 7'h12, 7'h7F, 7'h7F, 1'b1, 8'd2);
    tbl[14] = mk(1'b0, 4'h5, 7'h12, 7'h30, 7'h12, 7'h7F, 1'b1, 8'd3);
    tbl[15] = mk(1'b1, 4'h5, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 1'b0, 8'd0);

    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].r, tbl[i].d);
      chk($sformatf("vec%0d.hex0", i), int'(bus.hex0), int'(tbl[i].h0));
      chk($sformatf("vec%0d.hex1", i), int'(bus.hex1), int'(tbl[i].h1));
      chk($sformatf("vec%0d.hex2", i), int'(bus.hex2), int'(tbl[i].h2));
      chk($sformatf("vec%0d.hex3", i), int'(bus.hex3), int'(tbl[i].h3));
      chk($sformatf("vec%0d.busy", i), int'(bus.busy), int'(tbl[i].b));
      chk($sformatf("vec%0d.upd", i),  int'(bus.upd_cnt), int'(tbl[i].u));
    end

    // Restart from the OFF phase with a new value.
    cyc(1'b0, 4'h7);
    cyc(1'b0, 4'h7);
    cyc(1'b0, 4'h7);
    chk("restart.off_blank", int'(bus.hex0), 'h7F);
    cyc(1'b0, 4'h9);
    chk("restart.new_val", int'(bus.hex0), 'h10);
    chk("restart.busy", int'(bus.busy), 1);
    for (int i = 0; i < 9; i++) begin
      cyc(1'b0, 4'h9);
      check_model($sformatf("restart%0d", i));
    end
    chk("restart.idle", int'(bus.busy), 0);

    // History shift over five values, then a long hold of the last one.
    cyc(1'b1, 4'h0);
    for (int v = 1; v <= 5; v++) begin
      for (int j = 0; j < 10; j++) cyc(1'b0, 4'(v));
    end
    chk("shift.hex0", int'(bus.hex0), 'h12);
    chk("shift.hex1", int'(bus.hex1), 'h19);
    chk("shift.hex2", int'(bus.hex2), 'h30);
    chk("shift.hex3", int'(bus.hex3), 'h24);
    chk("shift.upd",  int'(bus.upd_cnt), 5);
    for (int j = 0; j < 10; j++) cyc(1'b0, 4'h5);
    chk("shift.hold_upd", int'(bus.upd_cnt), 5);

    // Counter wrap after 256 alternating captures.
    cyc(1'b1, 4'h0);
    for (int j = 0; j < 256; j++) begin
      cyc(1'b0, (j % 2 == 0) ? 4'h0 : 4'hF);
      if (j == 254) chk("wrap.255", int'(bus.upd_cnt), 255);
    end
    chk("wrap.zero", int'(bus.upd_cnt), 0);
    check_model("wrap");

    // Reset while the newest digit is in its ON phase.
    cyc(1'b0, 4'h2);
    chk("rstmid.on", int'(bus.busy), 1);
    cyc(1'b1, 4'h2);
    check_model("rstmid");

    // Random stimulus against the reference model.
    for (int i = 0; i < 2000; i++) begin
      logic       r;
      logic [3:0] d;
      r = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 3) == 0) d = 4'($urandom_range(0, 15));
      else if (m_hist.size() > 0) d = 4'(m_hist[0]);
      else d = 4'($urandom_range(0, 3));
      cyc(r, d);
      check_model($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seg_history.md
SEG_HISTORY -- requirements
Module: seg_history

Interface
REQ-001 SHALL have parameter BLINK_HALF, default 25_000_000, cycles per blink half-period (ON or OFF); legal range >= 1.
REQ-002 SHALL have parameter BLINKS, default 3, ON/OFF pairs after each update; legal range 1..15.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 data_in  input  4  value under observation (buffer output of the preceding stage).
REQ-006 hex0..hex3  output  7 each  active-low segments {g,f,e,d,c,b,a}; hex0 = newest value, hex3 = oldest.
REQ-007 busy  output  1  high while the blink sequence runs.
REQ-008 upd_cnt  output  8  count of captured updates, wraps 255->0.

Function
REQ-009 Update condition, per edge: valid[0]==0, or data_in != hist[0].
REQ-010 On update: hist[3..1] <= hist[2..0], valid[3..1] <= valid[2..0], hist[0] <= data_in, valid[0] <= 1, upd_cnt +1 mod 256.
REQ-011 No update: hist, valid and upd_cnt hold.
REQ-012 Digit N: seg(hist[N]) if valid[N], else blank 7'h7F; outputs decoded combinationally from registers, so visible right after the capturing edge.
REQ-013 Decode (hex): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
REQ-014 Blink FSM states: IDLE, ON, OFF; cnt = phase counter, left = remaining pairs.
REQ-015 Any update, in any state: next state ON, cnt <= 0, left <= BLINKS; blink restarts.
REQ-016 ON, no update: cnt increments; at cnt == BLINK_HALF-1 -> OFF, cnt <= 0.
REQ-017 OFF, no update: cnt increments; at cnt == BLINK_HALF-1: cnt <= 0, left <= left-1; next state IDLE if left==1, else ON.
REQ-018 IDLE: no counting; hex0 steady.
REQ-019 hex0 SHALL be forced to 7'h7F in OFF; hex1..hex3 never blink.
REQ-020 busy = (state != IDLE), combinational from state register.
REQ-021 Same value repeated: no update, no blink restart.
REQ-022 A change back to an older value: normal update; duplicates allowed in hist[1..3].

Reset
REQ-023 rst high at an edge: hist = 0, valid = 0, upd_cnt = 0, state = IDLE, cnt = 0, left = 0.
REQ-024 Same edge: no capture.
REQ-025 Reset wins over a simultaneous update.
REQ-026 During and right after reset: hex0..hex3 = 7'h7F, busy = 0.
REQ-027 First edge with rst low: unconditional capture of data_in (valid[0]==0), starts a blink.
REQ-028 Reset mid-blink: abort to IDLE, all digits blank.

Structure
REQ-029 Shared package SHALL hold: FSM state type (IDLE/ON/OFF), SEG_BLANK = 7'h7F, 16-entry segment table of REQ-013.
REQ-030 One sub-module hex_to_seg: combinational 4-bit -> 7-bit active-low decoder, instantiated four times.
REQ-031 cnt width: clog2(BLINK_HALF), minimum 1; left width: 4 bits.

Verification (BLINK_HALF=2, BLINKS=2 unless stated)
REQ-032 Reset scenario: rst high 2 cycles, data_in=5 -> all hex = 7F, busy=0. First edge after release -> hex0=12, hex1..3=7F, upd_cnt=1.
REQ-033 Blink timing: update at edge k -> hex0=seg in k..k+1, 7F in k+2..k+3, seg in k+4..k+5, 7F in k+6..k+7. From k+8: steady, busy=0.
REQ-034 History shift: data_in 1,2,3,4,5 (each held 10 cycles) -> hex0..3 = 12,19,30,24, upd_cnt=5. Holding 5 adds no updates.
REQ-035 Restart: change during OFF phase -> next cycle state ON, hex0 shows new value, full 2-pair sequence follows.
REQ-036 Wrap: 256 alternating changes 0/F -> upd_cnt returns to 0.
REQ-037 Reset mid-blink: rst asserted during ON -> next edge all hex 7F, busy=0, upd_cnt=0.
